// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first
// Carry is registered between chunks so the ripple chain is only CHUNK+1 bits long.
module chunked_add_sub #(
   parameter int N     = 16,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);

   localparam int STEPS = N / CHUNK;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nx;
   logic [N-1:0]   a_r, b_r;
   logic           carry;
   logic [CW-1:0]  cnt;
   logic [CHUNK-1:0] a_k, b_k;
   logic [CHUNK:0] sum;
   logic [N-1:0]   res_nx;
   logic           last;
   logic           msb_cin;

   assign last = (cnt == LAST);

   always_comb begin
      a_k    = '0;
      b_k    = '0;
      res_nx = result;
      for (int k = 0; k < STEPS; k++) begin
         if (cnt == CW'(k)) begin
            a_k = a_r[k*CHUNK +: CHUNK];
            b_k = b_r[k*CHUNK +: CHUNK];
         end
      end
      sum = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry};
      for (int k = 0; k < STEPS; k++) begin
         if (cnt == CW'(k)) res_nx[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end
   end

   // Sum bit = a ^ b ^ cin, so the carry into the MSB falls out of the MSB sum bit.
   assign msb_cin = a_r[N-1] ^ b_r[N-1] ^ sum[CHUNK-1];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid) state_nx = RUN;
         RUN:  if (last) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
         end
         if (state == RUN) begin
            result <= res_nx;
            carry  <= sum[CHUNK];
            cnt    <= cnt + 1'b1;
            if (last) begin
               cnt  <= '0;
               cout <= sum[CHUNK];
               ovf  <= msb_cin ^ sum[CHUNK];
               zero <= (res_nx == '0);
            end
         end
      end
   end

   assign in_ready  = (state == IDLE) && resetn;
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - scoreboard bench for chunked_add_sub in three configurations
module tb_chunked_add_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        iv[3];
   logic [31:0] av[3];
   logic [31:0] bv[3];
   logic        sv[3];
   logic        ordy[3];
   logic        ir[3];
   logic        ov[3];
   logic        co[3];
   logic        of[3];
   logic        zr[3];
   logic [15:0] r0, r1;
   logic [31:0] r2;

   int width_of[3] = '{16, 16, 32};
   int steps_of[3] = '{4, 1, 4};

   typedef struct {
      logic [31:0] res;
      logic        co;
      logic        of;
      logic        zr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   chunked_add_sub #(.N(16), .CHUNK(4)) u_d0 (
      .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(av[0][15:0]), .b(bv[0][15:0]), .sub(sv[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .result(r0), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

   chunked_add_sub #(.N(16), .CHUNK(16)) u_d1 (
      .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(av[1][15:0]), .b(bv[1][15:0]), .sub(sv[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .result(r1), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

   chunked_add_sub #(.N(32), .CHUNK(8)) u_d2 (
      .clk(clk), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(av[2]), .b(bv[2]), .sub(sv[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .result(r2), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

   function automatic logic [31:0] res_of(input int d);
      case (d)
         0:       return {16'h0, r0};
         1:       return {16'h0, r1};
         default: return r2;
      endcase
   endfunction

   function automatic exp_t model(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t        e;
      int          n;
      logic [31:0] mask, am, bm;
      logic [32:0] full;
      n    = width_of[d];
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      am   = a & mask;
      bm   = (s ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bm} + {32'd0, s};
      e.res = full[31:0] & mask;
      e.co  = full[n];
      e.of  = (am[n-1] == bm[n-1]) && (e.res[n-1] != am[n-1]);
      e.zr  = (e.res == 32'd0);
      return e;
   endfunction

   task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input bit noise, input string tag);
      int   lat;
      exp_t g;
      lat = 0;
      while (!ir[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      iv[d] = 1'b1; av[d] = a; bv[d] = b; sv[d] = s;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      sb.push_back(model(d, a, b, s));
      lat = 0;
      while (!ov[d] && lat < 40) begin
         if (noise) begin
            iv[d] = 1'($urandom_range(0, 1));
            av[d] = $urandom; bv[d] = $urandom;
            sv[d] = 1'($urandom_range(0, 1));
         end
         checks++;
         if (ir[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_ready: got %b want 0", tag, ir[d]);
         end
         @(posedge clk); #1;
         lat++;
      end
      iv[d] = 1'b0;
      checks++;
      if (lat !== steps_of[d]) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", tag, lat, steps_of[d]);
      end
      g = sb.pop_front();
      for (int h = 0; h <= hold; h++) begin
         checks++;
         if ({res_of(d), co[d], of[d], zr[d], ov[d], ir[d]} !== {g.res, g.co, g.of, g.zr, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s result(cyc %0d): got res=%h c=%b v=%b z=%b ov=%b ir=%b want res=%h c=%b v=%b z=%b ov=1 ir=0",
                     tag, h, res_of(d), co[d], of[d], zr[d], ov[d], ir[d], g.res, g.co, g.of, g.zr);
         end
         if (h < hold) begin
            @(posedge clk); #1;
         end
      end
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      ordy[d] = 1'b0;
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
         errors++;
         $display("FAIL %s handshake: got ov=%b ir=%b want ov=0 ir=1", tag, ov[d], ir[d]);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; av[d] = '0; bv[d] = '0; sv[d] = 1'b0; ordy[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({res_of(d), co[d], of[d], zr[d], ov[d]} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs d%0d: got res=%h c=%b v=%b z=%b ov=%b want all 0",
                     d, res_of(d), co[d], of[d], zr[d], ov[d]);
         end
      end
      resetn = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ir[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready d%0d: got %b want 1", d, ir[d]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      run_op(0, 32'h1234, 32'h0FCD, 1'b0, 0, 1'b0, "add_1234_0fcd");
      run_op(0, 32'hFFFF, 32'h0001, 1'b0, 0, 1'b0, "add_ffff_1");
      run_op(0, 32'h7FFF, 32'h0001, 1'b0, 0, 1'b0, "add_7fff_1");
   endtask

   task automatic test_sub();
      run_op(0, 32'h0005, 32'h0007, 1'b1, 0, 1'b0, "sub_5_7");
      run_op(0, 32'h8000, 32'h0001, 1'b1, 0, 1'b0, "sub_8000_1");
      run_op(0, 32'h0042, 32'h0042, 1'b1, 0, 1'b0, "sub_42_42");
   endtask

   task automatic test_backpressure();
      run_op(0, 32'hABCD, 32'h1357, 1'b0, 10, 1'b1, "backpressure_add");
      run_op(0, 32'h1000, 32'h2000, 1'b1, 10, 1'b1, "backpressure_sub");
   endtask

   task automatic test_back_to_back();
      run_op(0, 32'h0F0F, 32'h00F1, 1'b0, 0, 1'b0, "b2b_first");
      run_op(0, 32'h0000, 32'h0001, 1'b1, 0, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_mid();
      iv[0] = 1'b1; av[0] = 32'h1234; bv[0] = 32'h0FCD; sv[0] = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({r0, co[0], of[0], zr[0], ov[0]} !== 20'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got res=%h c=%b v=%b z=%b ov=%b want all 0",
                  r0, co[0], of[0], zr[0], ov[0]);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      #1;
      checks++;
      if (ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_in_ready: got %b want 1", ir[0]);
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         checks++;
         if (ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_spurious_valid cyc %0d: got %b want 0", c, ov[0]);
         end
      end
      run_op(0, 32'h0001, 32'h0001, 1'b0, 0, 1'b0, "after_reset_1_1");
   endtask

   task automatic test_configs();
      run_op(1, 32'h1234, 32'h0FCD, 1'b0, 0, 1'b0, "single_step_add");
      run_op(1, 32'h8000, 32'h0001, 1'b1, 2, 1'b0, "single_step_sub");
      run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, "w32_wrap");
      run_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0, "w32_sub_ovf");
   endtask

   task automatic test_random();
      logic [31:0] ra, rb;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
               0: rb = ra;
               1: ra = 32'hFFFF_FFFF;
               2: rb = 32'd0;
               default: ;
            endcase
            run_op(d, ra, rb, 1'($urandom_range(0, 1)), 0, i[0], "random");
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_configs();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chunked_add_sub.md
Name: chunked_add_sub

Overview:
- Multi-cycle, parametrised adder/subtractor for the calculator datapath.
- Processes an N-bit operand pair CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks.
- Trades latency for a short carry chain so wide operands meet timing on the DE10-Lite.
- Sits between the operand registers and the result/display path, with valid/ready handshakes on both sides.

Parameters:
- N, 16, operand/result width in bits; N >= 2.
- CHUNK, 4, bits added per cycle; N % CHUNK must equal 0. CHUNK = N gives the single-step case.
- STEPS, N/CHUNK, derived (localparam), number of processing cycles.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and sub are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  N  sum or difference, modulo 2^N.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow (A >= B unsigned).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- One clock. resetn is asynchronous and active-low; assertion at any time forces the idle/reset state immediately.
- Reset values: state=IDLE, out_valid=0, result=0, cout=0, ovf=0, zero=0, carry register=0, chunk counter=0. in_ready=1 once resetn deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE to RUN: on the edge where in_valid & in_ready.
  - Capture a, the effective B (b if sub=0, ~b if sub=1), and sub into internal registers.
  - Load carry = sub and counter = 0.
- RUN, each edge:
  - Chunk k = counter covers bits [k*CHUNK +: CHUNK].
  - Compute sum_k = A_k + B_k + carry as a combinational ripple within the chunk.
  - Write sum_k into the result shift/slice register, store the chunk carry-out into carry, and increment counter.
- Last chunk (counter == STEPS-1):
  - cout = chunk carry-out.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - zero = (full final result == 0).
  - Go to DONE. out_valid rises on this same edge.
- Latency: out_valid is first high STEPS edges after the accept edge. Defaults: 4 cycles. CHUNK=N: 1 cycle.
- DONE: result, cout, ovf, zero and out_valid are held stable until out_valid & out_ready. On that edge go to IDLE; out_valid=0 next cycle.
  - Output fields keep their last values after the handshake; they are don't-care while out_valid=0.
- No back-to-back overlap: a new accept happens no earlier than the cycle after a result handshake. Minimum initiation interval is STEPS+2 cycles.
- in_valid while not in_ready is ignored. Changes on a/b/sub after acceptance have no effect.
- out_ready while not out_valid is ignored.
- Widths and arithmetic:
  - Internal chunk adder is CHUNK+1 bits wide.
  - result wraps modulo 2^N; no saturation.
  - Carry into the MSB is taken from the bit-(N-2) carry inside the final chunk.
- Reset mid-operation (RUN or DONE): partial result discarded, all outputs return to reset values, no spurious out_valid afterwards.

Test Plan:
- Reset, then 0x1234 + 0x0FCD (sub=0) -> out_valid exactly 4 edges after accept. result=0x2201, cout=0, ovf=0, zero=0.
- 0xFFFF + 0x0001 -> result=0x0000, cout=1, ovf=0, zero=1. 0x7FFF + 0x0001 -> result=0x8000, cout=0, ovf=1.
- sub=1: 0x0005 - 0x0007 -> result=0xFFFE, cout=0, ovf=0. 0x8000 - 0x0001 -> result=0x7FFF, cout=1, ovf=1. 0x0042 - 0x0042 -> zero=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. Toggle in_valid and a/b during RUN -> no effect. Pulse out_ready -> IDLE next cycle.
- Drop resetn during RUN at chunk 2 of 0x1234 + 0x0FCD -> all outputs 0 immediately, in_ready=1 after release, no out_valid. A subsequent 0x0001 + 0x0001 -> 0x0002.
- Parameter sweeps:
  - N=16, CHUNK=16: 1-cycle latency.
  - N=32, CHUNK=8: 0xFFFFFFFF + 0x00000001 -> result=0, cout=1, zero=1, latency 4.
  - Random compare against a golden reference model over 1000 vectors for each configuration.
